// File: rtl/tinuc_dmem_arbiter.sv
// Two-port arbiter in front of the TinuC 1Kx32 data memory: the core (port 0)
// has priority, and the debug/DMA master (port 1) gets a forced slot after a bounded wait.
module tinuc_dmem_arbiter #(
  parameter int MAX_WAIT    = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   req0,
  input  logic                   we0,
  input  logic [9:0]             addr0,
  input  logic [31:0]            wdata0,
  output logic                   gnt0,
  output logic                   stall_core,
  output logic                   rvalid0,
  output logic [31:0]            rdata0,
  input  logic                   req1,
  input  logic                   we1,
  input  logic [9:0]             addr1,
  input  logic [31:0]            wdata1,
  output logic                   gnt1,
  output logic                   rvalid1,
  output logic [31:0]            rdata1,
  output logic [9:0]             mem_addr,
  output logic [31:0]            mem_wdata,
  output logic                   mem_we,
  input  logic [31:0]            mem_rdata,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [7:0]             MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX    = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE    = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   rd_tag0_q, rd_tag0_d;
  logic                   rd_tag1_q, rd_tag1_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic gnt0_c, gnt1_c, stall_c;

  always_comb begin
    gnt1_c  = RESET_N & req1 & (~req0 | (wait_cnt_q == MAX_WAIT_C));
    gnt0_c  = RESET_N & req0 & ~gnt1_c;
    // The RESET_N term keeps the stall low during reset even though req0 is ungranted.
    stall_c = RESET_N & req0 & ~gnt0_c;

    gnt0       = gnt0_c;
    gnt1       = gnt1_c;
    stall_core = stall_c;

    mem_addr  = addr0;
    mem_wdata = wdata0;
    mem_we    = 1'b0;
    if (gnt1_c) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end else if (gnt0_c) begin
      mem_we = we0;
    end

    rvalid0 = rd_tag0_q;
    rvalid1 = rd_tag1_q;
    rdata0  = mem_rdata;
    rdata1  = mem_rdata;
    stall_cnt = stall_cnt_q;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt1_c || !req1) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    rd_tag0_d = gnt0_c & ~we0;
    rd_tag1_d = gnt1_c & ~we1;

    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wait_cnt_q  <= 8'd0;
      rd_tag0_q   <= 1'b0;
      rd_tag1_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rd_tag0_q   <= rd_tag0_d;
      rd_tag1_q   <= rd_tag1_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_tinuc_dmem_arbiter.sv
// Bench for tinuc_dmem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a rule-level model of priority, starvation and memory.
module tb_tinuc_dmem_arbiter;

  localparam int MW = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [9:0]  addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, stall_core, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [9:0]  mem_addr;
  logic [15:0] stall_cnt;

  logic        s_gnt0, s_gnt1, s_stall, s_rvalid0, s_rvalid1, s_mem_we;
  logic [31:0] s_rdata0, s_rdata1, s_mem_wdata;
  logic [9:0]  s_mem_addr;
  logic [3:0]  s_stall_cnt;

  logic [31:0] mem       [0:1023];
  logic [31:0] model_mem [0:1023];

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  tinuc_dmem_arbiter #(.MAX_WAIT(MW), .STALL_CNT_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .stall_core(stall_core), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation checks.
  tinuc_dmem_arbiter #(.MAX_WAIT(MW), .STALL_CNT_W(4)) dut_s (
    .CLK(CLK), .RESET_N(RESET_N),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(s_gnt0), .stall_core(s_stall), .rvalid0(s_rvalid0), .rdata0(s_rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(s_gnt1), .rvalid1(s_rvalid1), .rdata1(s_rdata1),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we),
    .mem_rdata(mem_rdata), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic rn, r0, w0; logic [9:0] a0; logic [31:0] d0;
    logic r1, w1; logic [9:0] a1; logic [31:0] d1;
    logic g0, g1, st, mwe, rv0, rv1, crd; logic [31:0] rd; logic [15:0] scnt;
  } vec_t;

  function automatic vec_t mk(logic rn, logic r0, logic w0, logic [9:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [9:0] a1, logic [31:0] d1,
                              logic g0, logic g1, logic st, logic mwe, logic rv0, logic rv1,
                              logic crd, logic [31:0] rd, logic [15:0] scnt);
    vec_t v;
    v.rn = rn; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.st = st; v.mwe = mwe; v.rv0 = rv0; v.rv1 = rv1;
    v.crd = crd; v.rd = rd; v.scnt = scnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge, then return at the falling edge for sampling.
  task automatic step(input logic rn_i, input logic r0_i, input logic w0_i, input logic [9:0] a0_i,
                      input logic [31:0] d0_i, input logic r1_i, input logic w1_i,
                      input logic [9:0] a1_i, input logic [31:0] d1_i);
    @(posedge CLK);
    #1;
    RESET_N = rn_i; req0 = r0_i; we0 = w0_i; addr0 = a0_i; wdata0 = d0_i;
    req1 = r1_i; we1 = w1_i; addr1 = a1_i; wdata1 = d1_i;
    @(negedge CLK);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  vec_t vecs [0:16];

  // Reference model state for the randomized phase.
  int          m_streak, m_scnt;
  logic        m_pend0, m_pend1;
  logic [31:0] m_pdata;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]       = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
      model_mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
    end
    mem[5] = 32'hCAFEF00D;

    step(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);

    // ---------------- directed vector table ----------------
    vecs[0] = mk(0, 1,1,10'h000,32'h0, 1,1,10'h000,32'h0, 0,0,0,0, 0,0, 0,32'h0, 16'd0);
    vecs[1] = mk(1, 1,0,10'h005,32'h0, 0,0,10'h000,32'h0, 1,0,0,0, 0,0, 0,32'h0, 16'd0);
    vecs[2] = mk(1, 0,0,10'h000,32'h0, 0,0,10'h000,32'h0, 0,0,0,0, 1,0, 1,32'hCAFEF00D, 16'd0);
    vecs[3] = mk(1, 0,0,10'h000,32'h0, 1,1,10'h3FF,32'h12345678, 0,1,0,1, 0,0, 0,32'h0, 16'd0);
    vecs[4] = mk(1, 0,0,10'h000,32'h0, 1,0,10'h3FF,32'h0, 0,1,0,0, 0,0, 0,32'h0, 16'd0);
    vecs[5] = mk(1, 0,0,10'h000,32'h0, 0,0,10'h000,32'h0, 0,0,0,0, 0,1, 1,32'h12345678, 16'd0);
    for (int k = 0; k < 10; k++) begin
      logic fg;
      fg = (k == 4) || (k == 9);
      vecs[6+k] = mk(1, 1,1,10'h020,32'h11111111, 1,1,10'h021,32'h22222222,
                     !fg, fg, fg, 1, 0,0, 0,32'h0, (k < 5) ? 16'd0 : 16'd1);
    end
    vecs[16] = mk(1, 0,0,10'h000,32'h0, 0,0,10'h000,32'h0, 0,0,0,0, 0,0, 0,32'h0, 16'd2);

    for (int i = 0; i < 17; i++) begin
      vec_t v;
      v = vecs[i];
      step(v.rn, v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1);
      $display("vec %0d: gnt0=%b gnt1=%b stall=%b mem_we=%b rvalid0=%b rvalid1=%b stall_cnt=%0d",
               i, gnt0, gnt1, stall_core, mem_we, rvalid0, rvalid1, stall_cnt);
      chk($sformatf("vec%0d_gnt0", i), {31'd0, gnt0}, {31'd0, v.g0});
      chk($sformatf("vec%0d_gnt1", i), {31'd0, gnt1}, {31'd0, v.g1});
      chk($sformatf("vec%0d_stall", i), {31'd0, stall_core}, {31'd0, v.st});
      chk($sformatf("vec%0d_mem_we", i), {31'd0, mem_we}, {31'd0, v.mwe});
      chk($sformatf("vec%0d_rvalid0", i), {31'd0, rvalid0}, {31'd0, v.rv0});
      chk($sformatf("vec%0d_rvalid1", i), {31'd0, rvalid1}, {31'd0, v.rv1});
      chk($sformatf("vec%0d_stall_cnt", i), {16'd0, stall_cnt}, {16'd0, v.scnt});
      if (v.g1) chk($sformatf("vec%0d_mem_addr", i), {22'd0, mem_addr}, {22'd0, v.a1});
      if (v.g0) chk($sformatf("vec%0d_mem_addr", i), {22'd0, mem_addr}, {22'd0, v.a0});
      if (v.mwe) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, v.g1 ? v.d1 : v.d0);
      if (v.crd && v.rv0) chk($sformatf("vec%0d_rdata0", i), rdata0, v.rd);
      if (v.crd && v.rv1) chk($sformatf("vec%0d_rdata1", i), rdata1, v.rd);
    end

    // ---------------- wait counter clears when req1 drops ----------------
    for (int k = 0; k < 3; k++) begin
      step(1, 1,1,10'h022,32'h33333333, 1,1,10'h023,32'h44444444);
      chk($sformatf("clr_pre%0d_gnt1", k), {31'd0, gnt1}, 32'd0);
    end
    step(1, 1,1,10'h022,32'h33333333, 0,0,10'h023,32'h0);
    chk("clr_withdraw_gnt0", {31'd0, gnt0}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      step(1, 1,1,10'h022,32'h33333333, 1,1,10'h023,32'h44444444);
      $display("clr k=%0d gnt0=%b gnt1=%b", k, gnt0, gnt1);
      chk($sformatf("clr_re%0d_gnt1", k), {31'd0, gnt1}, {31'd0, (k == 4)});
    end
    idle();
    chk("clr_stall_cnt", {16'd0, stall_cnt}, 32'd3);

    // ---------------- reset in the cycle after a read grant ----------------
    step(1, 1,0,10'h005,32'h0, 0,0,10'h0,32'h0);
    chk("rstrd_gnt0", {31'd0, gnt0}, 32'd1);
    step(0, 1,0,10'h005,32'h0, 1,1,10'h0,32'h0);
    chk("rstrd_low_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rstrd_low_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rstrd_low_stall", {31'd0, stall_core}, 32'd0);
    chk("rstrd_low_mem_we", {31'd0, mem_we}, 32'd0);
    idle();
    chk("rstrd_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rstrd_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("rstrd_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rstrd_gnt0_after", {31'd0, gnt0}, 32'd0);

    // ---------------- stall counter saturation (4-bit instance) ----------------
    for (int k = 0; k < 100; k++) begin
      step(1, 1,1,10'h030,32'h55555555, 1,1,10'h031,32'h66666666);
      if (k == 70) begin
        chk("sat_mid_main", {16'd0, stall_cnt}, 32'd14);
        chk("sat_mid_narrow", {28'd0, s_stall_cnt}, 32'd14);
      end
    end
    idle();
    $display("saturation: stall_cnt=%0d narrow=%0d", stall_cnt, s_stall_cnt);
    chk("sat_main", {16'd0, stall_cnt}, 32'd20);
    chk("sat_narrow", {28'd0, s_stall_cnt}, 32'd15);

    // ---------------- randomized traffic vs. reference model ----------------
    step(0, 0,0,10'h0,32'h0, 0,0,10'h0,32'h0);
    m_streak = 0; m_scnt = 0; m_pend0 = 0; m_pend1 = 0; m_pdata = 32'h0;
    begin
      logic rn, r0, w0, r1, w1, held, e_g0, e_g1, e_st, e_mwe;
      logic [9:0] a0, a1;
      logic [31:0] d0, d1;
      held = 0; r0 = 0; w0 = 0; a0 = 0; d0 = 0;
      for (int c = 0; c < 400; c++) begin
        rn = ($urandom_range(0, 49) != 0);
        if (!held) begin
          r0 = ($urandom_range(0, 3) != 0);
          w0 = $urandom_range(0, 1) == 1;
          a0 = 10'h100 + 10'($urandom_range(0, 63));
          d0 = $urandom;
        end
        r1 = $urandom_range(0, 1) == 1;
        w1 = $urandom_range(0, 1) == 1;
        a1 = 10'h100 + 10'($urandom_range(0, 63));
        d1 = $urandom;
        step(rn, r0, w0, a0, d0, r1, w1, a1, d1);

        e_g1  = rn && r1 && (!r0 || (m_streak == MW));
        e_g0  = rn && r0 && !e_g1;
        e_st  = rn && r0 && !e_g0;
        e_mwe = (e_g0 && w0) || (e_g1 && w1);
        if (e_g0 || e_g1)
          $display("rnd %0d: port%0d %s addr=0x%03h", c, e_g1 ? 1 : 0,
                   (e_g1 ? w1 : w0) ? "WR" : "RD", e_g1 ? a1 : a0);

        chk("rnd_gnt0", {31'd0, gnt0}, {31'd0, e_g0});
        chk("rnd_gnt1", {31'd0, gnt1}, {31'd0, e_g1});
        chk("rnd_stall", {31'd0, stall_core}, {31'd0, e_st});
        chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, e_mwe});
        chk("rnd_rvalid0", {31'd0, rvalid0}, {31'd0, m_pend0});
        chk("rnd_rvalid1", {31'd0, rvalid1}, {31'd0, m_pend1});
        chk("rnd_stall_cnt", {16'd0, stall_cnt}, (m_scnt > 65535) ? 32'd65535 : 32'(m_scnt));
        chk("rnd_n_stall_cnt", {28'd0, s_stall_cnt}, (m_scnt > 15) ? 32'd15 : 32'(m_scnt));
        chk("rnd_n_gnt", {30'd0, s_gnt1, s_gnt0}, {30'd0, e_g1, e_g0});
        chk("rnd_n_stall_we", {30'd0, s_stall, s_mem_we}, {30'd0, e_st, e_mwe});
        chk("rnd_n_rvalid", {30'd0, s_rvalid1, s_rvalid0}, {30'd0, m_pend1, m_pend0});
        if (e_g0 || e_g1) begin
          chk("rnd_mem_addr", {22'd0, mem_addr}, {22'd0, e_g1 ? a1 : a0});
          chk("rnd_n_mem_addr", {22'd0, s_mem_addr}, {22'd0, e_g1 ? a1 : a0});
        end
        if (e_mwe) begin
          chk("rnd_mem_wdata", mem_wdata, e_g1 ? d1 : d0);
          chk("rnd_n_mem_wdata", s_mem_wdata, e_g1 ? d1 : d0);
        end
        if (m_pend0) chk("rnd_rdata0", rdata0, m_pdata);
        if (m_pend1) chk("rnd_rdata1", rdata1, m_pdata);
        if (m_pend0) chk("rnd_n_rdata0", s_rdata0, m_pdata);
        if (m_pend1) chk("rnd_n_rdata1", s_rdata1, m_pdata);

        if (!rn) begin
          m_streak = 0; m_pend0 = 0; m_pend1 = 0; m_scnt = 0;
        end else begin
          if (e_g1 || !r1) m_streak = 0;
          else if (m_streak < MW) m_streak = m_streak + 1;
          m_pend0 = e_g0 && !w0;
          m_pend1 = e_g1 && !w1;
          if (e_g0) begin
            if (w0) model_mem[a0] = d0; else m_pdata = model_mem[a0];
          end
          if (e_g1) begin
            if (w1) model_mem[a1] = d1; else m_pdata = model_mem[a1];
          end
          if (e_st) m_scnt = m_scnt + 1;
        end
        held = e_st;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tinuc_dmem_arbiter.md
# tinuc_dmem_arbiter

Shares the single 1K×32 data memory of the TinuC segmented core between the core's MEM stage (port 0) and an external debug/DMA master (port 1). Port 0 has priority. A starvation counter guarantees port 1 a slot after a bounded wait. When port 0 loses a cycle, the block raises a stall toward the core's pipeline freeze logic. Read data returns with a fixed 1-cycle latency from the synchronous-read memory and is tagged to the requesting port.

## Interface
- MAX_WAIT, 4, cycles port 1 may be denied while requesting before it is forced a grant (legal range 1..255)
- STALL_CNT_W, 16, width of the saturating stall-cycle counter

- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  synchronous, active-low reset
- req0 / we0  in  1 / 1  core access request / write enable (write when 1)
- addr0  in  10  core word address
- wdata0  in  32  core write data
- gnt0  out  1  core access accepted this cycle
- stall_core  out  1  core must hold MEM stage and all earlier stages this cycle
- rvalid0  out  1  rdata0 valid (read granted previous cycle)
- rdata0  out  32  core read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same widths and meanings, for port 1
- mem_addr  out  10  memory address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory read data, valid 1 cycle after address
- stall_cnt  out  STALL_CNT_W  number of cycles with stall_core=1 since reset, saturating

## Operation
- State: wait_cnt (8 bit), rd_tag0, rd_tag1 (1 bit each), stall_cnt.
- Grant, combinational from the current request inputs and wait_cnt:
  - gnt1 = req1 & (!req0 | wait_cnt == MAX_WAIT)
  - gnt0 = req0 & !gnt1
  - At most one grant per cycle.
- stall_core = req0 & !gnt0. While stalled, the core holds req0/we0/addr0/wdata0 stable.
- Memory mux:
  - gnt1: drives addr1/wdata1, with mem_we = we1.
  - gnt0: drives addr0/wdata0, with mem_we = we0.
  - No grant: mem_we = 0. mem_addr and mem_wdata hold port 0 values as don't-care.
- wait_cnt update, next cycle:
  - Cleared to 0 if gnt1 or !req1.
  - Otherwise incremented when req1 & !gnt1, saturating at MAX_WAIT.
- Read tags: rd_tag0 <= gnt0 & !we0 and rd_tag1 <= gnt1 & !we1. rvalid0 = rd_tag0 and rvalid1 = rd_tag1.
- rdata0 = rdata1 = mem_rdata. The data is meaningful only where the matching rvalid is 1.
- Writes produce no response beyond the grant.
- stall_cnt increments each cycle stall_core=1 and saturates at all-ones.
- Reset (RESET_N=0 at a rising edge): wait_cnt, rd_tags and stall_cnt are cleared to 0.
- While RESET_N is low, gnt0, gnt1, stall_core and mem_we are forced to 0 combinationally.
- Reset mid-read: an rvalid that would have fired the cycle after reset is dropped (outputs 0).

## Timing
- Grant and memory drive happen in the same cycle as the request (zero-latency decision).
- Read data arrives at cycle N+1 for a read granted at cycle N. Back-to-back reads by either port, or alternating ports, reach full throughput of 1 access per cycle.
- Port 1 worst-case latency with port 0 requesting continuously is MAX_WAIT+1 cycles from the first req1 to gnt1.
- After a forced port 1 grant, wait_cnt = 0. Port 0 therefore wins the next contested cycle, so port 1 gets at most 1 of every MAX_WAIT+1 contested cycles.
- Simultaneous write by one port and read response to the other: permitted. rvalid belongs to the previous cycle's grant.
- Reset values: gnt0=0, gnt1=0, stall_core=0, rvalid0=0, rvalid1=0, mem_we=0, stall_cnt=0. rdata and mem_addr are don't-care.

## Test plan
- **Core-only reads:** req0=1, we0=0, addr0=0x005, mem holding 0xCAFEF00D. Required: gnt0=1 the same cycle; next cycle rvalid0=1, rdata0=0xCAFEF00D, rvalid1=0; stall_core never 1.
- **Contention with MAX_WAIT=4:** req0 and req1 held high from cycle 0. Required: gnt0 in cycles 0-3, gnt1 and stall_core=1 in cycle 4, gnt0 in cycle 5, gnt1 again in cycle 9; stall_cnt=2 after cycle 9.
- **Port 1 alone:** req1 write (addr1=0x3FF, wdata1=0x12345678), then read of 0x3FF. Required: gnt1 both cycles, mem_we=1 only on the first, rvalid1=1 with 0x12345678 one cycle after the read grant.
- **Counter clear:** req1 withdrawn at wait_cnt=3 (MAX_WAIT=4), then reasserted. Required: the next forced gnt1 comes 4 cycles after reassertion, not 1.
- **Reset mid-read:** RESET_N=0 in the cycle after a gnt0 read. Required: rvalid0=0 the following cycle, all outputs at reset values, and stall_cnt=0.
- **Saturation:** with STALL_CNT_W=4 and 20 stall cycles, stall_cnt=15.
